// File: rtl/spi_master_gen.sv
// spi_master_gen: burst SPI master with runtime CPOL/CPHA, programmable SCLK divider, one-hot SS.
// Optional feature macro: SPI_MASTER_LOOPBACK_EN adds loopback_i (MOSI looped into receive path).
module spi_master_gen #(
   parameter int unsigned MAX_BYTES = 4,
   parameter int unsigned NUM_SS    = 2,
   parameter int unsigned CLK_DIV_W = 8,
   localparam int unsigned SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
   localparam int unsigned NB_W     = $clog2(MAX_BYTES + 1),
   localparam int unsigned DW       = 8 * MAX_BYTES
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 cpol_i,
   input  logic                 cpha_i,
   input  logic [CLK_DIV_W-1:0] clk_div_i,
   input  logic [SS_W-1:0]      ss_sel_i,
   input  logic [NB_W-1:0]      num_bytes_i,
   input  logic [DW-1:0]        tx_data_i,
   input  logic                 spi_miso_i,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic                 loopback_i,
`endif
   output logic                 busy_o,
   output logic                 done_o,
   output logic [DW-1:0]        rx_data_o,
   output logic [NB_W-1:0]      rx_bytes_valid_o,
   output logic                 spi_clk_o,
   output logic                 spi_mosi_o,
   output logic [NUM_SS-1:0]    spi_ss_o
);

   localparam int unsigned BW  = $clog2(DW);
   localparam int unsigned E_W = BW + 1;

   typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StDone} state_e;

   state_e               r_state;
   logic                 r_cpol;
   logic                 r_cpha;
   logic                 r_loop;
   logic [CLK_DIV_W-1:0] r_div;
   logic [CLK_DIV_W-1:0] r_div_cnt;
   logic [DW-1:0]        r_tx;
   logic [E_W-1:0]       r_edge;
   logic [E_W-1:0]       r_last_edge;
   logic [7:0]           r_rx_sh;
   logic                 r_busy;
   logic                 r_done;
   logic [DW-1:0]        r_rx_data;
   logic [NB_W-1:0]      r_rx_valid;
   logic                 r_sclk;
   logic                 r_mosi;
   logic [NUM_SS-1:0]    r_ss;

   logic                 w_loop_in;
   logic [NB_W-1:0]      w_n;
   logic [E_W-1:0]       w_last_edge;
   logic [BW-1:0]        w_bit;
   logic [BW-1:0]        w_bit_nxt;
   logic                 w_tx_cur;
   logic                 w_tx_nxt;
   logic                 w_miso;
   logic [7:0]           w_rx_byte;
   logic                 w_tick;
   logic                 w_sample;
   logic [NUM_SS-1:0]    w_ss_dec;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign w_loop_in = loopback_i;
`else
   assign w_loop_in = 1'b0;
`endif

   assign w_n         = (num_bytes_i > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : num_bytes_i;
   // Last SCLK edge index is 16*N-1, i.e. {N-1, 4'hF}.
   assign w_last_edge = E_W'({w_n - NB_W'(1), 4'hF});

   // Two SCLK edges per bit; XOR with 7 maps bit order to MSB-first within each byte.
   assign w_bit     = r_edge[E_W-1:1];
   assign w_bit_nxt = w_bit + BW'(1);
   assign w_tx_cur  = r_tx[w_bit ^ BW'(7)];
   assign w_tx_nxt  = r_tx[w_bit_nxt ^ BW'(7)];

   assign w_miso    = r_loop ? r_mosi : spi_miso_i;
   assign w_rx_byte = {r_rx_sh[6:0], w_miso};
   assign w_tick    = (r_div_cnt == r_div);
   // Even edges lead; CPHA=0 samples on leading, CPHA=1 on trailing.
   assign w_sample  = ~r_edge[0] ^ r_cpha;

   always_comb begin
      w_ss_dec = '1;
      for (int i = 0; i < int'(NUM_SS); i++) begin
         if (ss_sel_i == SS_W'(i)) w_ss_dec[i] = 1'b0;
      end
      if (w_loop_in) w_ss_dec = '1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= StIdle;
         r_cpol      <= 1'b0;
         r_cpha      <= 1'b0;
         r_loop      <= 1'b0;
         r_div       <= '0;
         r_div_cnt   <= '0;
         r_tx        <= '0;
         r_edge      <= '0;
         r_last_edge <= '0;
         r_rx_sh     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rx_data   <= '0;
         r_rx_valid  <= '0;
         r_sclk      <= 1'b0;
         r_mosi      <= 1'b0;
         r_ss        <= '1;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               r_sclk <= cpol_i;
               if (start_i) begin
                  r_cpol      <= cpol_i;
                  r_cpha      <= cpha_i;
                  r_loop      <= w_loop_in;
                  r_div       <= clk_div_i;
                  r_tx        <= tx_data_i;
                  r_last_edge <= w_last_edge;
                  r_div_cnt   <= '0;
                  r_edge      <= '0;
                  r_rx_data   <= '0;
                  r_rx_valid  <= '0;
                  r_busy      <= 1'b1;
                  if (w_n == '0) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= StSetup;
                     r_ss    <= w_ss_dec;
                     r_mosi  <= cpha_i ? 1'b0 : tx_data_i[7];
                  end
               end
            end
            StSetup: begin
               r_sclk <= r_cpol;
               if (w_tick) begin
                  r_div_cnt <= '0;
                  r_state   <= StXfer;
               end else begin
                  r_div_cnt <= r_div_cnt + CLK_DIV_W'(1);
               end
            end
            StXfer: begin
               if (w_tick) begin
                  r_div_cnt <= '0;
                  r_sclk    <= ~r_sclk;
                  r_edge    <= r_edge + E_W'(1);
                  if (w_sample) begin
                     r_rx_sh <= w_rx_byte;
                     if (w_bit[2:0] == 3'd7) begin
                        for (int k = 0; k < int'(MAX_BYTES); k++) begin
                           if ((w_bit >> 3) == BW'(k)) r_rx_data[8*k +: 8] <= w_rx_byte;
                        end
                        r_rx_valid <= r_rx_valid + NB_W'(1);
                     end
                  end else if (r_edge != r_last_edge) begin
                     r_mosi <= r_cpha ? w_tx_cur : w_tx_nxt;
                  end
                  if (r_edge == r_last_edge) r_state <= StHold;
               end else begin
                  r_div_cnt <= r_div_cnt + CLK_DIV_W'(1);
               end
            end
            StHold: begin
               r_sclk <= r_cpol;
               if (w_tick) begin
                  r_div_cnt <= '0;
                  r_state   <= StDone;
                  r_done    <= 1'b1;
                  r_ss      <= '1;
               end else begin
                  r_div_cnt <= r_div_cnt + CLK_DIV_W'(1);
               end
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy_o           = r_busy;
   assign done_o           = r_done;
   assign rx_data_o        = r_rx_data;
   assign rx_bytes_valid_o = r_rx_valid;
   assign spi_clk_o        = r_sclk;
   assign spi_mosi_o       = r_mosi;
   assign spi_ss_o         = r_ss;

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench for spi_master_gen: cycle-level SPI slave model plus burst-level expectations.
module tb_spi_master_gen;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        cpol_i;
   logic        cpha_i;
   logic [7:0]  clk_div_i;
   logic        ss_sel_i;
   logic [2:0]  num_bytes_i;
   logic [31:0] tx_data_i;
   logic        spi_miso;
   logic        loopback = 1'b0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] rx_data_o;
   logic [2:0]  rx_bytes_valid_o;
   logic        spi_clk_o;
   logic        spi_mosi_o;
   logic [1:0]  spi_ss_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spi_master_gen #(
      .MAX_BYTES(4),
      .NUM_SS   (2),
      .CLK_DIV_W(8)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .cpol_i          (cpol_i),
      .cpha_i          (cpha_i),
      .clk_div_i       (clk_div_i),
      .ss_sel_i        (ss_sel_i),
      .num_bytes_i     (num_bytes_i),
      .tx_data_i       (tx_data_i),
      .spi_miso_i      (spi_miso),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback_i      (loopback),
`endif
      .busy_o          (busy_o),
      .done_o          (done_o),
      .rx_data_o       (rx_data_o),
      .rx_bytes_valid_o(rx_bytes_valid_o),
      .spi_clk_o       (spi_clk_o),
      .spi_mosi_o      (spi_mosi_o),
      .spi_ss_o        (spi_ss_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Serial bit k of a burst word: byte k/8 first, MSB first.
   function automatic logic bit_of(input logic [31:0] w, input int k);
      return w[8*(k/8) + 7 - (k%8)];
   endfunction

   task automatic run_burst(input logic cpol, input logic cpha, input logic [7:0] div,
                            input logic ss, input logic [2:0] n, input logic [31:0] tx,
                            input logic [31:0] miso, input bit hold);
      int          nc, busy_cyc, done_cnt, leads, edges, ncap, idx, ss_err, step_err, cyc, limit;
      logic        prev_sclk, lead;
      bit          seen_done;
      logic [31:0] cap, mask, exp_rx;
      logic [1:0]  pat;
      logic [2:0]  prev_valid;
      cpol_i = cpol; cpha_i = cpha; clk_div_i = div; ss_sel_i = ss;
      num_bytes_i = n; tx_data_i = tx; start_i = 1'b0;
      @(negedge clk);
      nc = (n > 3'd4) ? 4 : int'(n);
      mask = '0;
      for (int b = 0; b < nc; b++) mask[8*b +: 8] = 8'hFF;
      pat = 2'b11;
      if (nc > 0 && !loopback) pat[ss] = 1'b0;
      busy_cyc = 0; done_cnt = 0; leads = 0; edges = 0; ncap = 0; idx = 0;
      ss_err = 0; step_err = 0; cyc = 0; seen_done = 0; cap = '0; prev_valid = '0;
      limit = 66 * (int'(div) + 1) + 20;
      check("idle_sclk", spi_clk_o, cpol);
      prev_sclk = spi_clk_o;
      spi_miso = bit_of(miso, 0);
      start_i = 1'b1;
      while (cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (!hold) begin
            start_i = 1'b0;
         end else begin
            tx_data_i = $urandom; num_bytes_i = 3'($urandom); clk_div_i = 8'($urandom);
            ss_sel_i = 1'($urandom); cpha_i = 1'($urandom);
         end
         if (busy_o) busy_cyc++;
         if (done_o) done_cnt++;
         if (spi_ss_o !== ((busy_o && !done_o) ? pat : 2'b11)) ss_err++;
         if (rx_bytes_valid_o != prev_valid) begin
            if (rx_bytes_valid_o != prev_valid + 3'd1) step_err++;
            prev_valid = rx_bytes_valid_o;
         end
         if (spi_clk_o !== prev_sclk) begin
            lead = (prev_sclk == cpol);
            edges++;
            if (lead) leads++;
            if (lead ^ cpha) begin
               if (ncap < 32) cap[8*(ncap/8) + 7 - (ncap%8)] = spi_mosi_o;
               ncap++;
            end else if (cpha) begin
               if (idx < 32) spi_miso = bit_of(miso, idx);
               idx++;
            end else begin
               idx++;
               if (idx < 32) spi_miso = bit_of(miso, idx);
            end
            prev_sclk = spi_clk_o;
         end
         if (done_o) seen_done = 1;
         if (seen_done && !busy_o) break;
      end
      exp_rx = (loopback ? tx : miso) & mask;
      check("finished", {31'd0, seen_done && !busy_o}, 1);
      check("busy_cycles", busy_cyc, (nc == 0) ? 1 : (16 * nc + 2) * (int'(div) + 1) + 1);
      check("done_pulses", done_cnt, 1);
      check("sclk_periods", leads, 8 * nc);
      check("sclk_edges", edges, 16 * nc);
      check("mosi_bits", ncap, 8 * nc);
      check("mosi_data", cap, tx & mask);
      check("rx_data", rx_data_o, exp_rx);
      check("rx_valid", rx_bytes_valid_o, nc);
      check("ss_pattern", ss_err, 0);
      check("rx_valid_step", step_err, 0);
      check("sclk_idle_after", spi_clk_o, cpol);
      if (hold) begin
         // start_i still high: the DUT must now accept a fresh burst from IDLE.
         num_bytes_i = 3'd1; clk_div_i = 8'd0;
         @(negedge clk);
         check("restart_accept", busy_o, 1);
         start_i = 1'b0;
         cyc = 0;
         while (busy_o && cyc < 40) begin
            @(negedge clk);
            cyc++;
         end
         check("restart_finish", busy_o, 0);
      end
   endtask

   initial begin
      int cyc;
      rst_i = 1'b1; start_i = 1'b0; cpol_i = 1'b1; cpha_i = 1'b0; clk_div_i = '0;
      ss_sel_i = 1'b0; num_bytes_i = '0; tx_data_i = '0; spi_miso = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_rx", rx_data_o, 0);
      check("rst_valid", rx_bytes_valid_o, 0);
      check("rst_sclk", spi_clk_o, 0);
      check("rst_mosi", spi_mosi_o, 0);
      check("rst_ss", spi_ss_o, 2'b11);
      rst_i = 1'b0;
      @(negedge clk);

      run_burst(1'b0, 1'b0, 8'd0, 1'b0, 3'd1, 32'h0000_00A5, 32'h0000_003C, 0);
      run_burst(1'b1, 1'b1, 8'd3, 1'b1, 3'd4, 32'h1122_3344, 32'h5A6B_7C8D, 0);
      run_burst(1'b0, 1'b1, 8'd2, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
      run_burst(1'b1, 1'b0, 8'd1, 1'b1, 3'd7, $urandom, $urandom, 0);
      run_burst(1'b0, 1'b0, 8'd1, 1'b0, 3'd2, 32'hDEAD_BEEF, $urandom, 1);
      run_burst(1'b1, 1'b1, 8'd255, 1'b0, 3'd1, $urandom, $urandom, 0);
      for (int i = 0; i < 20; i++) begin
         run_burst(1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)), 1'($urandom),
                   3'($urandom), $urandom, $urandom, 0);
      end

      // Reset in the middle of a 2-byte transfer.
      cpol_i = 1'b0; cpha_i = 1'b0; clk_div_i = 8'd1; ss_sel_i = 1'b0;
      num_bytes_i = 3'd2; tx_data_i = $urandom; spi_miso = 1'b1;
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 0;
      while (rx_bytes_valid_o != 3'd1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_valid", rx_bytes_valid_o, 1);
      rst_i = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_ss", spi_ss_o, 2'b11);
      check("mid_rst_sclk", spi_clk_o, 0);
      check("mid_rst_valid", rx_bytes_valid_o, 0);
      check("mid_rst_done", done_o, 0);
      check("mid_rst_rx", rx_data_o, 0);
      rst_i = 1'b0;
      @(negedge clk);
      check("post_rst_done", done_o, 0);

`ifdef SPI_MASTER_LOOPBACK_EN
      loopback = 1'b1;
      for (int m = 0; m < 4; m++) begin
         run_burst(1'(m >> 1), 1'(m), 8'd1, 1'b0, 3'd1, 32'h0000_00C3, $urandom, 0);
      end
      loopback = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised, mode-configurable SPI master for the accelerator SoC. It replaces the fixed-mode, single-slave SPI master with the following:
- Runtime CPOL/CPHA selection.
- Programmable SCLK divider.
- NUM_SS one-hot active-low slave selects.
- Burst transfers of 1..MAX_BYTES bytes.
- An explicit start/busy/done handshake towards the bus-side controller.

It sits between the memory-mapped SPI register block and the board-level SPI pins.

Parameters:
MAX_BYTES, 4, maximum bytes per burst; tx/rx buses are 8*MAX_BYTES wide.
NUM_SS, 2, number of slave-select lines.
CLK_DIV_W, 8, width of the clock-divider input.

Ports:
clk_i  in  1  system clock; all logic on rising edge.
rst_i  in  1  synchronous, active-high reset.
start_i  in  1  request a burst; sampled only in IDLE.
cpol_i  in  1  SCLK idle level.
cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge.
clk_div_i  in  CLK_DIV_W  SCLK half-period = clk_div_i+1 clk_i cycles (H).
ss_sel_i  in  max(1,$clog2(NUM_SS))  index of slave to select.
num_bytes_i  in  $clog2(MAX_BYTES+1)  bytes in burst.
tx_data_i  in  8*MAX_BYTES  byte k at [8k+7:8k]; byte 0 sent first.
spi_miso_i  in  1  serial input.
busy_o  out  1  high while a burst is in progress.
done_o  out  1  one-cycle pulse at end of burst.
rx_data_o  out  8*MAX_BYTES  received byte k at [8k+7:8k].
rx_bytes_valid_o  out  $clog2(MAX_BYTES+1)  count of completed received bytes.
spi_clk_o  out  1  SCLK.
spi_mosi_o  out  1  serial output.
spi_ss_o  out  NUM_SS  active-low selects; at most one low.

Behaviour:
- Reset values: busy_o=0, done_o=0, rx_data_o=0, rx_bytes_valid_o=0, spi_clk_o=0, spi_mosi_o=0, spi_ss_o=all 1s. All internal counters 0, state IDLE.
- rst_i mid-burst: on the next edge, return to IDLE with reset values; no done_o pulse.
- Outputs are registered. Bits go MSB first within each byte.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
- IDLE:
  - spi_clk_o follows cpol_i (registered).
  - When start_i=1, latch cpol, cpha, clk_div, ss_sel, tx_data and N=num_bytes_i.
  - On that latch: clear rx_data_o and rx_bytes_valid_o.
  - N=0: go directly to DONE (single done_o pulse, SS never asserted, busy_o high 1 cycle).
  - N>MAX_BYTES: clamp to MAX_BYTES.
  - ss_sel >= NUM_SS: no SS line is asserted; the burst still runs.
- SETUP (H cycles):
  - spi_ss_o[ss_sel]=0.
  - SCLK at idle level.
  - CPHA=0: MOSI drives bit 7 of byte 0.
- XFER (16*N*H cycles): SCLK toggles every H cycles, giving 8*N full SCLK periods.
  - CPHA=0: sample MISO on each leading edge; shift MOSI on each trailing edge (except after the final bit).
  - CPHA=1: shift MOSI on each leading edge (first leading edge drives bit 7); sample on each trailing edge.
  - After every 8th sample: write the byte to rx_data_o slot k and increment rx_bytes_valid_o in the same cycle.
- HOLD (H cycles): SCLK idle, SS still asserted.
- DONE (1 cycle):
  - done_o=1, SS all high.
  - busy_o falls on the next edge.
  - start_i is not accepted in DONE.
- busy_o timing: high from the cycle after start acceptance through DONE inclusive, for (16N+2)*H+1 cycles.
- start_i while busy_o=1: ignored; input changes mid-burst have no effect.
- rx_data_o and rx_bytes_valid_o hold their values after DONE until the next accepted start.
- The divider counter is CLK_DIV_W bits and wraps at clk_div latched; clk_div=max value gives H=2^CLK_DIV_W.

Optional Feature:
SPI_MASTER_LOOPBACK_EN
- Defined: adds input loopback_i (1 bit), latched at start. When the latched value is 1, the receive path samples internal MOSI instead of spi_miso_i, and spi_ss_o stays all 1s for the burst.
- Undefined: no loopback_i port; the receive path always uses spi_miso_i.

Test Plan:
- Mode 0, div=0, N=1, tx=0xA5, MISO slave returns 0x3C -> MOSI shows 1010_0101 on rising edges; rx_data_o[7:0]=0x3C; busy_o high exactly 19 cycles; single done_o pulse; spi_ss_o[0] low throughout SETUP..HOLD.
- Mode 3 (cpol=1, cpha=1), div=3, N=4, tx=0x11223344, ss_sel=1 -> SCLK idles high; H=4 cycles; bytes sent in order 0x44,0x33,0x22,0x11; rx_bytes_valid_o steps 1..4; only spi_ss_o[1] low.
- N=0 start -> done_o pulses without SS or SCLK activity; N=7 with MAX_BYTES=4 -> exactly 32 SCLK periods.
- start_i held high through a burst, tx_data changed mid-burst -> only one burst; original data transmitted; second start accepted only in IDLE after DONE.
- rst_i asserted mid-XFER of a 2-byte burst -> next cycle busy_o=0, SS all 1s, SCLK=0, rx_bytes_valid_o=0, no done_o.
- With SPI_MASTER_LOOPBACK_EN, loopback_i=1, tx=0xC3 -> rx_data_o[7:0]=0xC3 in all four CPOL/CPHA modes; SS never asserted.
